// File: rtl/bitstream_player_pkg.sv
// Shared definitions for the bitstream player: FSM encodings, word width and
// the UART symbol-timing derivation used by the ACIA blocks.
package bitstream_player_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        LOAD_LO,
        LOAD_HI,
        PRIME0,
        PRIME1,
        PLAY
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic int sym_cnt_f(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Counter width able to hold 0 .. sym_cnt-1.
    function automatic int scw_f(input int sym_cnt);
        return (sym_cnt > 1) ? $clog2(sym_cnt) : 1;
    endfunction

endpackage

// File: rtl/bitstream_player_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, start-bit qualify at half symbol,
// mid-bit sampling of 8 data bits LSB first, stop-bit check on rx_err.
module acia_rx
    import bitstream_player_pkg::*;
#(
    parameter int SYM_CNT = 40000,
    parameter int SCW     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    output logic       rx_err
);

    localparam logic [SCW-1:0] HALF = SCW'(SYM_CNT / 2 - 1);
    localparam logic [SCW-1:0] FULL = SCW'(SYM_CNT - 1);

    logic [1:0]     sync;
    logic           rx_s;
    rx_state_t      state, state_nx;
    logic [SCW-1:0] cnt, cnt_nx;
    logic [2:0]     bit_idx, bit_nx;
    logic [7:0]     shreg, shreg_nx;
    logic           stb_nx, err_nx;

    assign rx_s   = sync[1];
    assign rx_dat = shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= 2'b11;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            rx_stb  <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            sync    <= {sync[0], rx_serial};
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            shreg   <= shreg_nx;
            rx_stb  <= stb_nx;
            rx_err  <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        stb_nx   = 1'b0;
        err_nx   = rx_err;
        case (state)
            RX_IDLE: begin
                cnt_nx = '0;
                if (!rx_s) state_nx = RX_START;
            end
            RX_START: begin
                // A start bit that is no longer low at half symbol is a glitch.
                if (cnt == HALF) begin
                    cnt_nx   = '0;
                    bit_nx   = '0;
                    state_nx = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL) begin
                    cnt_nx   = '0;
                    shreg_nx = {rx_s, shreg[7:1]};
                    bit_nx   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_nx = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL) begin
                    cnt_nx   = '0;
                    stb_nx   = 1'b1;
                    err_nx   = ~rx_s;
                    state_nx = RX_IDLE;
                end
            end
            default: state_nx = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/bitstream_player.sv
// Loads a 2**AW x 16 image from UART (low byte then high byte per word) and
// replays it forever MSB-first, one bit per enabled clk, on sig_out.
module bitstream_player
    import bitstream_player_pkg::*;
#(
    parameter int CLK_FREQ = 48000000,
    parameter int BAUD     = 1200,
    parameter int AW       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic fpga_rx,
    input  logic play_en,
    output logic sig_out,
    output logic loaded,
    output logic frame_err
);

    localparam int SYM_CNT = sym_cnt_f(CLK_FREQ, BAUD);
    localparam int SCW     = scw_f(SYM_CNT);

    logic [7:0]        rx_dat;
    logic              rx_stb, rx_err, good_stb;
    state_t            state, state_nx;
    logic [AW-1:0]     waddr, raddr;
    logic [3:0]        bit_cnt;
    logic [WORD_W-1:0] shreg, rdata, wdata;
    logic [7:0]        lo_byte;
    logic              we, last_addr;

    logic [WORD_W-1:0] mem [0:2**AW-1];

    acia_rx #(.SYM_CNT(SYM_CNT), .SCW(SCW)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (fpga_rx),
        .rx_dat    (rx_dat),
        .rx_stb    (rx_stb),
        .rx_err    (rx_err)
    );

    assign good_stb  = rx_stb & ~rx_err;
    assign last_addr = (waddr == '1);
    assign wdata     = {rx_dat, lo_byte};

    // Single-clock RAM with registered read; maps onto one SB_RAM40_4K.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

    always_comb begin
        state_nx = state;
        we       = 1'b0;
        case (state)
            LOAD_LO: if (good_stb) state_nx = LOAD_HI;
            LOAD_HI: begin
                if (good_stb) begin
                    we       = 1'b1;
                    state_nx = last_addr ? PRIME0 : LOAD_LO;
                end
            end
            PRIME0:  state_nx = PRIME1;
            PRIME1:  state_nx = PLAY;
            PLAY:    state_nx = PLAY;
            default: state_nx = LOAD_LO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD_LO;
            waddr     <= '0;
            raddr     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            sig_out   <= 1'b0;
            loaded    <= 1'b0;
            frame_err <= 1'b0;
            lo_byte   <= '0;
        end else begin
            state <= state_nx;
            if (rx_stb && rx_err) frame_err <= 1'b1;
            if (state == LOAD_LO && good_stb) lo_byte <= rx_dat;
            if (we) begin
                waddr <= waddr + 1'b1;
                if (last_addr) loaded <= 1'b1;
            end
            // raddr has been 0 since reset, so rdata holds word 0 here.
            if (state == PRIME1) begin
                shreg   <= rdata;
                raddr   <= AW'(1);
                bit_cnt <= '0;
            end
            if (state == PLAY) begin
                if (play_en) begin
                    sig_out <= shreg[WORD_W-1];
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 4'd15) begin
                        shreg <= rdata;
                        raddr <= raddr + 1'b1;
                    end else begin
                        shreg <= {shreg[WORD_W-2:0], 1'b0};
                    end
                end else begin
                    sig_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitstream_player.sv
// Randomised self-checking bench for bitstream_player: UART upload, then a
// bit-exact comparison of the replayed stream against an array-based model.
module tb_bitstream_player;

    localparam int SYM    = 4;
    localparam int DEPTH  = 256;
    localparam int PERIOD = 16 * DEPTH;

    logic clk, rst, fpga_rx, play_en;
    logic sig_out, loaded, frame_err;

    int   n_checks, n_errors;
    logic [15:0] ref_mem [0:DEPTH-1];
    logic [7:0]  lo, hi;
    int   tmo, pos, cyc, pause_left;
    logic pe_used, paused, expb;

    bitstream_player #(.CLK_FREQ(SYM), .BAUD(1), .AW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .fpga_rx   (fpga_rx),
        .play_en   (play_en),
        .sig_out   (sig_out),
        .loaded    (loaded),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drives one 8N1 frame starting at a negedge; a bad frame is followed by idle.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        fpga_rx = 1'b0;
        repeat (SYM) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            fpga_rx = b[i];
            repeat (SYM) @(negedge clk);
        end
        fpga_rx = stop_ok;
        repeat (SYM) @(negedge clk);
        fpga_rx = 1'b1;
        if (!stop_ok) repeat (SYM) @(negedge clk);
    endtask

    // Bit p of the endless stream: words in address order, MSB first.
    function automatic logic exp_bit(input int p);
        int w;
        w = (p / 16) % DEPTH;
        return ref_mem[w][15 - (p % 16)];
    endfunction

    task automatic play_loop();
        pos = 0; cyc = 0; pause_left = 0;
        paused = 1'b0; pe_used = 1'b1; play_en = 1'b1;
        while (pos < 2 * PERIOD + 16 && cyc < 3 * PERIOD) begin
            @(negedge clk);
            cyc++;
            if (pe_used) begin
                expb = exp_bit(pos);
                pos++;
            end else begin
                expb = 1'b0;
            end
            check("sig_out", {31'd0, sig_out}, {31'd0, expb});
            if (pause_left > 0) begin
                play_en = 1'b0;
                pause_left--;
            end else if (!paused && pos == 10 * 16 + 7) begin
                play_en = 1'b0;
                pause_left = 36;
                paused = 1'b1;
            end else if (pos > PERIOD + 16 && $urandom_range(0, 15) == 0) begin
                play_en = 1'b0;
            end else begin
                play_en = 1'b1;
            end
            pe_used = play_en;
        end
        check("play_complete", {31'd0, (pos >= 2 * PERIOD + 16)}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0;
        fpga_rx = 1'b1; play_en = 1'b1; rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sig_out", {31'd0, sig_out}, 32'd0);
        check("rst_loaded", {31'd0, loaded}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Partial load left in LOAD_HI with a framing error, then reset.
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b1);
        repeat (4) @(negedge clk);
        check("pre_rst_frame_err", {31'd0, frame_err}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_sig_out", {31'd0, sig_out}, 32'd0);
        check("mid_rst_loaded", {31'd0, loaded}, 32'd0);
        check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full image, with a bad frame between the bytes of word 4.
        for (int w = 0; w < DEPTH; w++) begin
            hi = 8'(w);
            lo = ~hi;
            ref_mem[w] = {hi, lo};
            send_byte(lo, 1'b1);
            if (w == 4) begin
                check("frame_err_before_bad", {31'd0, frame_err}, 32'd0);
                send_byte(8'($urandom), 1'b0);
                repeat (2) @(negedge clk);
                check("frame_err_sticky", {31'd0, frame_err}, 32'd1);
            end
            if (w == DEPTH - 1) check("loaded_before_last", {31'd0, loaded}, 32'd0);
            send_byte(hi, 1'b1);
        end

        tmo = 0;
        while (!loaded && tmo < 8 * SYM) begin
            @(negedge clk);
            tmo++;
        end
        check("loaded_rise", {31'd0, loaded}, 32'd1);
        check("sig_out_at_write", {31'd0, sig_out}, 32'd0);
        @(negedge clk);
        check("sig_out_prime0", {31'd0, sig_out}, 32'd0);
        @(negedge clk);
        check("sig_out_prime1", {31'd0, sig_out}, 32'd0);

        // Bytes arriving during playback must not disturb the stored image.
        fork
            begin
                repeat (100) @(negedge clk);
                for (int k = 0; k < 6; k++) send_byte(8'($urandom), 1'b1);
            end
            play_loop();
        join

        check("loaded_hold", {31'd0, loaded}, 32'd1);
        check("frame_err_hold", {31'd0, frame_err}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
